// File: rtl/crash_sequencer_pkg.sv
// Shared definitions for the crash sequencer: FSM state encoding, lives width and
// the helper that sizes the frame counter.
package crash_sequencer_pkg;

  localparam int unsigned LIVES_W = 3;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StCrash  = 3'd2,
    StInvuln = 3'd3,
    StOver   = 3'd4
  } state_e;

  // Bits needed to hold max(a, b) - 1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/crash_sequencer_frame_timer.sv
// Frame-tick gated counter with synchronous clear and saturation.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   clear_i   forces the count to zero (dominates tick_i)
//   tick_i    advance by one (ignored once the count is all ones)
//   tc_val_i  terminal count compared against the current count
//   tc_o      high while the count equals tc_val_i
module crash_sequencer_frame_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [Width-1:0] tc_val_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/crash_sequencer.sv
// Turns a raw player/enemy overlap into the game-level crash sequence: freeze during
// the crash window, lose a life, respawn, invulnerability window, game over.
// Optional feature macro: INVULN_BLINK_EN (player sprite blinks while invulnerable).
// Ports:
//   clk_i, reset_i (sync, active high), frame_tick_i, start_i, colision_i
//   crash_active_o, player_freeze_o, player_visible_o, invulnerable_o, respawn_o,
//   respawn_x_o[7:0], lives_o[2:0], game_over_o -- all registered.
module crash_sequencer
  import crash_sequencer_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned CRASH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter logic [7:0]  RESPAWN_X     = 8'd100
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               colision_i,
  output logic               crash_active_o,
  output logic               player_freeze_o,
  output logic               player_visible_o,
  output logic               invulnerable_o,
  output logic               respawn_o,
  output logic [7:0]         respawn_x_o,
  output logic [LIVES_W-1:0] lives_o
  ,output logic              game_over_o
);

  localparam int unsigned CntW = cnt_width(CRASH_FRAMES, INVULN_FRAMES);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               respawn_d;
  logic               crash_q, freeze_q, visible_q, visible_d, invuln_q, respawn_q, over_q;

  logic               st_tc, st_clr;
  logic [CntW-1:0]    st_tc_val;

  // One timer serves both windows; its terminal value follows the current state.
  assign st_tc_val = (state_q == StCrash) ? CntW'(CRASH_FRAMES - 1) : CntW'(INVULN_FRAMES - 1);
  assign st_clr    = start_i || (state_d != state_q) ||
                     !((state_q == StCrash) || (state_q == StInvuln));

  crash_sequencer_frame_timer #(
    .Width(CntW)
  ) u_state_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (st_clr),
    .tick_i  (frame_tick_i),
    .tc_val_i(st_tc_val),
    .tc_o    (st_tc)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    if (start_i) begin
      // Restart beats a same-cycle collision.
      state_d   = StRun;
      lives_d   = LIVES_W'(LIVES_INIT);
      respawn_d = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (colision_i) begin
            state_d = StCrash;
            lives_d = lives_q - LIVES_W'(1);
          end
        end
        StCrash: begin
          if (frame_tick_i && st_tc) begin
            if (lives_q == '0) begin
              state_d = StOver;
            end else begin
              state_d   = StInvuln;
              respawn_d = 1'b1;
            end
          end
        end
        StInvuln: begin
          if (frame_tick_i && st_tc) begin
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INVULN_BLINK_EN
  localparam int unsigned BlinkW = cnt_width(BLINK_PERIOD, 1);

  logic blink_tc, blink_clr;

  // Restart the blink period on entry, on every toggle, and whenever not invulnerable.
  assign blink_clr = (state_q != StInvuln) || (state_d != StInvuln) || (frame_tick_i && blink_tc);

  crash_sequencer_frame_timer #(
    .Width(BlinkW)
  ) u_blink_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (blink_clr),
    .tick_i  (frame_tick_i),
    .tc_val_i(BlinkW'(BLINK_PERIOD - 1)),
    .tc_o    (blink_tc)
  );

  always_comb begin
    visible_d = 1'b1;
    if ((state_q == StInvuln) && (state_d == StInvuln)) begin
      visible_d = (frame_tick_i && blink_tc) ? ~visible_q : visible_q;
    end
  end
`else
  assign visible_d = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      lives_q   <= '0;
      crash_q   <= 1'b0;
      freeze_q  <= 1'b1;
      visible_q <= 1'b1;
      invuln_q  <= 1'b0;
      respawn_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      crash_q   <= (state_d == StCrash);
      freeze_q  <= (state_d == StIdle) || (state_d == StCrash) || (state_d == StOver);
      visible_q <= visible_d;
      invuln_q  <= (state_d == StInvuln);
      respawn_q <= respawn_d;
      over_q    <= (state_d == StOver);
    end
  end

  assign crash_active_o   = crash_q;
  assign player_freeze_o  = freeze_q;
  assign player_visible_o = visible_q;
  assign invulnerable_o   = invuln_q;
  assign respawn_o        = respawn_q;
  assign respawn_x_o      = RESPAWN_X;
  assign lives_o          = lives_q;
  assign game_over_o      = over_q;

endmodule
